uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning braud_x16 ticks per bit period (even, >=4).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning flops in rx input synchronizer.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port braud_x16  input  1  one-clk-wide sample-enable tick, OVERSAMPLE per bit.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port out_rx  output  8  last correctly framed byte, LSB received first.
REQ-008 SHALL have port recived_signal  output  1  one-clk pulse: out_rx updated with a new byte.
REQ-009 SHALL have port framing_error  output  1  one-clk pulse: stop bit sampled low.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL pass rx through SYNC_STAGES flops, reset value 1; all decisions use the synchronized value rx_s.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, BREAK; the tick counter and bit counter advance only on clk edges where braud_x16=1.
REQ-013 IDLE: on tick with rx_s=0 -> START, tick counter cleared to 0.
REQ-014 START: on tick counter reaching OVERSAMPLE/2-1 sample rx_s; 0 -> DATA with counters cleared; 1 -> IDLE (false start, no outputs asserted).
REQ-015 DATA: sample rx_s every OVERSAMPLE ticks after the start-bit midpoint; shift into the MSB of the shift register (LSB-first); after 8th sample -> STOP.
REQ-016 STOP: sample rx_s OVERSAMPLE ticks after the 8th data sample; 1 -> out_rx <= shift register, recived_signal=1 for exactly the next clk, -> IDLE.
REQ-017 STOP with rx_s=0 -> framing_error=1 for exactly one clk, out_rx unchanged, recived_signal stays 0, -> BREAK.
REQ-018 BREAK: remain until a tick with rx_s=1, then -> IDLE; no new start is detected while in BREAK.
REQ-019 Latency: recived_signal rises on the clk edge following the stop-bit midpoint tick; a start edge found in IDLE on the very next tick SHALL be accepted (back-to-back frames, no idle gap required).
REQ-020 out_rx SHALL hold its value between valid frames; recived_signal and framing_error never assert in the same cycle.
REQ-021 braud_x16 held low SHALL freeze the state, counters and shift register; outputs hold except one-clk pulses, which deassert.
REQ-022 busy SHALL equal (state != IDLE), combinationally from the state register.

Reset
REQ-023 On reset=1, asynchronously: state=IDLE, counters=0, shift register=0, out_rx=8'h00, recived_signal=0, framing_error=0, busy=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame without a pulse on any output; reception restarts at the next falling edge after reset release.

Verification
REQ-025 OVERSAMPLE=16, frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> out_rx=8'hA5, one recived_signal pulse, framing_error=0.
REQ-026 rx low for 4 ticks then high -> state returns to IDLE, no recived_signal, no framing_error, out_rx unchanged.
REQ-027 frame 0x3C with stop bit 0, rx held low 3 bit periods -> one framing_error pulse, out_rx keeps previous value, busy high until rx returns high.
REQ-028 back-to-back 0x00 then 0xFF with no idle bits -> two recived_signal pulses, out_rx=8'h00 then 8'hFF.
REQ-029 reset pulsed during bit 4 of a frame -> all outputs reset values immediately, no pulse; next frame 0x5A received correctly.
REQ-030 braud_x16 gated off for 50 clks mid-DATA during 0x81 frame (rx held stable) -> reception resumes, out_rx=8'h81.

Source files
------------

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   Oversampling 8N1 UART receiver. The serial input is synchronised, a start
//   bit is qualified at its midpoint, and eight data bits (LSB first) plus the
//   stop bit are each sampled at their midpoints. A good stop bit publishes
//   the byte. A low stop bit reports a framing error, and the receiver then
//   waits in BREAK until the line goes high again.
//
// Parameters
//   OVERSAMPLE  : braud_x16 ticks per bit period (even, >= 4)
//   SYNC_STAGES : flops in the rx input synchroniser (>= 1)
//
// Ports
//   clk            in   system clock, all state on the rising edge
//   reset          in   asynchronous, active-high reset
//   braud_x16      in   one-clk sample-enable tick, OVERSAMPLE ticks per bit
//   rx             in   asynchronous serial line, idle high
//   out_rx[7:0]    out  last correctly framed byte
//   recived_signal out  one-clk pulse when out_rx takes a new byte
//   framing_error  out  one-clk pulse when the stop bit is sampled low
//   busy           out  high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_receiver #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       braud_x16,
    input  logic       rx,
    output logic [7:0] out_rx,
    output logic       recived_signal,
    output logic       framing_error,
    output logic       busy
);

    localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_ZERO = TW'(0);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rx_s;

    state_t        state_r;
    state_t        state_next_s;
    logic [TW-1:0] tick_cnt_r;
    logic [TW-1:0] tick_cnt_next_s;
    logic [2:0]    bit_cnt_r;
    logic [2:0]    bit_cnt_next_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_next_s;
    logic [7:0]    out_rx_r;
    logic [7:0]    out_rx_next_s;
    logic          recived_r;
    logic          recived_next_s;
    logic          ferr_r;
    logic          ferr_next_s;

    // Input synchroniser: idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= '1;
        end else begin
            sync_r[0] <= rx;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign rx_s = sync_r[SYNC_STAGES-1];

    // Next-state, counter, shift and output computation; nothing moves
    // without a tick except the pulses, which fall back to zero.
    always_comb begin
        state_next_s    = state_r;
        tick_cnt_next_s = tick_cnt_r;
        bit_cnt_next_s  = bit_cnt_r;
        shift_next_s    = shift_r;
        out_rx_next_s   = out_rx_r;
        recived_next_s  = 1'b0;
        ferr_next_s     = 1'b0;

        if (braud_x16) begin
            case (state_r)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_next_s    = ST_START;
                        tick_cnt_next_s = TICK_ZERO;
                    end else begin
                        state_next_s    = ST_IDLE;
                    end
                end
                ST_START: begin
                    // Midpoint of the start bit: a high line here was a glitch.
                    if (tick_cnt_r == HALF_LAST) begin
                        tick_cnt_next_s = TICK_ZERO;
                        bit_cnt_next_s  = 3'd0;
                        if (!rx_s) begin
                            state_next_s = ST_DATA;
                        end else begin
                            state_next_s = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_next_s = tick_cnt_r + TICK_ONE;
                    end
                end
                ST_DATA: begin
                    if (tick_cnt_r == FULL_LAST) begin
                        tick_cnt_next_s = TICK_ZERO;
                        // LSB arrives first, so shift in at the top.
                        shift_next_s    = {rx_s, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
                            bit_cnt_next_s = 3'd0;
                            state_next_s   = ST_STOP;
                        end else begin
                            bit_cnt_next_s = bit_cnt_r + 3'd1;
                        end
                    end else begin
                        tick_cnt_next_s = tick_cnt_r + TICK_ONE;
                    end
                end
                ST_STOP: begin
                    if (tick_cnt_r == FULL_LAST) begin
                        tick_cnt_next_s = TICK_ZERO;
                        if (rx_s) begin
                            out_rx_next_s  = shift_r;
                            recived_next_s = 1'b1;
                            state_next_s   = ST_IDLE;
                        end else begin
                            ferr_next_s    = 1'b1;
                            state_next_s   = ST_BREAK;
                        end
                    end else begin
                        tick_cnt_next_s = tick_cnt_r + TICK_ONE;
                    end
                end
                ST_BREAK: begin
                    // Only a high line ends a break; lows are not new starts.
                    if (rx_s) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_BREAK;
                    end
                end
                default: begin
                    state_next_s    = ST_IDLE;
                    tick_cnt_next_s = TICK_ZERO;
                    bit_cnt_next_s  = 3'd0;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= TICK_ZERO;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            out_rx_r   <= 8'h00;
            recived_r  <= 1'b0;
            ferr_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            tick_cnt_r <= tick_cnt_next_s;
            bit_cnt_r  <= bit_cnt_next_s;
            shift_r    <= shift_next_s;
            out_rx_r   <= out_rx_next_s;
            recived_r  <= recived_next_s;
            ferr_r     <= ferr_next_s;
        end
    end

    assign out_rx         = out_rx_r;
    assign recived_signal = recived_r;
    assign framing_error  = ferr_r;
    assign busy           = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
//   Self-checking bench for uart_receiver (OVERSAMPLE=16, SYNC_STAGES=2).
//   Frames are produced as bit sequences held for whole bit periods, counted
//   in baud ticks. The model is simply "a frame with a high stop bit yields
//   its data byte; a low stop bit yields one framing error". A monitor
//   collects every output pulse so the counts and byte order can be compared.
// ---------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int OS  = 16;
    localparam int DIV = 4;   // clocks per baud tick

    logic       clk;
    logic       reset;
    logic       braud_x16;
    logic       rx;
    logic [7:0] out_rx;
    logic       recived_signal;
    logic       framing_error;
    logic       busy;

    logic       tick_en;
    int         div_cnt;

    int         checks;
    int         failures;
    int         recv_cnt;
    int         ferr_cnt;
    int         both_cnt;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_good;

    uart_receiver #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .braud_x16      (braud_x16),
        .rx             (rx),
        .out_rx         (out_rx),
        .recived_signal (recived_signal),
        .framing_error  (framing_error),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick source: one clock in DIV, suppressed while tick_en is low.
    initial begin
        braud_x16 = 1'b0;
        div_cnt   = 0;
        forever begin
            @(negedge clk);
            div_cnt   = (div_cnt + 1) % DIV;
            braud_x16 = tick_en && (div_cnt == 0);
        end
    end

    // Pulse monitor.
    always @(negedge clk) begin
        if (recived_signal) begin
            recv_cnt++;
            got_q.push_back(out_rx);
        end
        if (framing_error) ferr_cnt++;
        if (recived_signal && framing_error) both_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Wait for n baud ticks, then step just past the edge.
    task automatic wait_ticks(input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            do begin
                @(posedge clk);
                guard++;
            end while (!braud_x16 && guard < 100);
            if (guard >= 100) begin
                checks++;
                failures++;
                $display("FAIL tick_timeout got=%0d exp=<100", guard);
            end
        end
        #1;
    endtask

    task automatic drive_bit(input logic b, input int nticks);
        rx = b;
        wait_ticks(nticks);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        drive_bit(1'b0, OS);
        for (int i = 0; i < 8; i++) drive_bit(data[i], OS);
        drive_bit(stop_bit, OS);
    endtask

    int         r0, f0;
    logic [7:0] b;
    logic [7:0] g;
    int         nb;
    int         gap;

    initial begin
        checks = 0; failures = 0; recv_cnt = 0; ferr_cnt = 0; both_cnt = 0;
        tick_en = 1'b1;
        rx      = 1'b1;
        reset   = 1'b1;
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_out_rx", {24'd0, out_rx}, 32'h00);
        check_eq("rst_recv",   {31'd0, recived_signal}, 32'd0);
        check_eq("rst_ferr",   {31'd0, framing_error}, 32'd0);
        check_eq("rst_busy",   {31'd0, busy}, 32'd0);
        reset = 1'b0;
        wait_ticks(2 * OS);

        // Single good frame.
        r0 = recv_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1);
        drive_bit(1'b1, OS);
        check_eq("a5_out", {24'd0, out_rx}, 32'hA5);
        check_eq("a5_pulses", recv_cnt - r0, 1);
        check_eq("a5_ferr", ferr_cnt - f0, 0);
        last_good = 8'hA5;

        // Glitch shorter than half a bit is rejected.
        r0 = recv_cnt; f0 = ferr_cnt;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 2 * OS);
        check_eq("glitch_busy", {31'd0, busy}, 32'd0);
        check_eq("glitch_recv", recv_cnt - r0, 0);
        check_eq("glitch_ferr", ferr_cnt - f0, 0);
        check_eq("glitch_out", {24'd0, out_rx}, {24'd0, last_good});

        // Low stop bit followed by a held break.
        r0 = recv_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        drive_bit(1'b0, 2 * OS);
        check_eq("break_busy", {31'd0, busy}, 32'd1);
        check_eq("break_ferr", ferr_cnt - f0, 1);
        check_eq("break_recv", recv_cnt - r0, 0);
        check_eq("break_out", {24'd0, out_rx}, {24'd0, last_good});
        drive_bit(1'b1, 2);
        check_eq("break_exit_busy", {31'd0, busy}, 32'd0);
        drive_bit(1'b1, OS);

        // Back-to-back frames with no idle time between them.
        got_q.delete();
        r0 = recv_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drive_bit(1'b1, OS);
        check_eq("b2b_pulses", recv_cnt - r0, 2);
        nb = got_q.size();
        check_eq("b2b_qsize", nb, 2);
        if (nb >= 2) begin
            g = got_q.pop_front();
            check_eq("b2b_first", {24'd0, g}, 32'h00);
            g = got_q.pop_front();
            check_eq("b2b_second", {24'd0, g}, 32'hFF);
        end
        check_eq("b2b_out", {24'd0, out_rx}, 32'hFF);

        // Reset in the middle of data bit 4.
        r0 = recv_cnt; f0 = ferr_cnt;
        b = 8'hE7;
        drive_bit(1'b0, OS);
        for (int i = 0; i < 4; i++) drive_bit(b[i], OS);
        drive_bit(b[4], OS / 2);
        reset = 1'b1;
        #2;
        check_eq("midrst_out", {24'd0, out_rx}, 32'h00);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        rx = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_ticks(2 * OS);
        check_eq("midrst_no_pulse", (recv_cnt - r0) + (ferr_cnt - f0), 0);
        send_frame(8'h5A, 1'b1);
        drive_bit(1'b1, OS);
        check_eq("after_rst_out", {24'd0, out_rx}, 32'h5A);
        check_eq("after_rst_pulse", recv_cnt - r0, 1);

        // Tick gating in the middle of a data bit.
        r0 = recv_cnt;
        b = 8'h81;
        drive_bit(1'b0, OS);
        for (int i = 0; i < 3; i++) drive_bit(b[i], OS);
        drive_bit(b[3], 5);
        tick_en = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check_eq("gate_busy", {31'd0, busy}, 32'd1);
        tick_en = 1'b1;
        wait_ticks(OS - 5);
        for (int i = 4; i < 8; i++) drive_bit(b[i], OS);
        drive_bit(1'b1, OS);
        drive_bit(1'b1, OS);
        check_eq("gate_out", {24'd0, out_rx}, 32'h81);
        check_eq("gate_pulse", recv_cnt - r0, 1);
        last_good = 8'h81;

        // Randomised frames against the model.
        got_q.delete();
        exp_q.delete();
        r0 = recv_cnt; f0 = ferr_cnt;
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                send_frame(b, 1'b0);
                drive_bit(1'b0, OS * $urandom_range(0, 2));
                drive_bit(1'b1, OS);
            end else begin
                send_frame(b, 1'b1);
                exp_q.push_back(b);
                last_good = b;
            end
            check_eq("rand_out", {24'd0, out_rx}, {24'd0, last_good});
            gap = $urandom_range(0, 2);
            drive_bit(1'b1, OS * gap);
        end
        drive_bit(1'b1, OS);
        check_eq("rand_recv_cnt", recv_cnt - r0, exp_q.size());
        check_eq("rand_ferr_cnt", ferr_cnt - f0, 24 - exp_q.size());
        nb = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nb; i++) begin
            check_eq("rand_byte", {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        end
        check_eq("both_pulses", both_cnt, 0);
        check_eq("final_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
